doppler_frame_sequencer: RTL and testbench
==========================================

Name: doppler_frame_sequencer

Overview:
- Sequences one Doppler measurement end to end: collects a frame of FFT_LEN echo samples, streams them into the streaming FFT, scans the output bins for the peak, and drives the shared 32-bit divider to produce signed velocity.
- Sits between the receiver front-end (echo_detected / receiver_data) and the fftmain + divider instances in the velocity path.
- Replaces ad hoc valid gating with an explicit frame FSM.

Parameters:
- FFT_LEN, 1024, points per FFT frame (power of two).
- BIN_HZ, 98, Hz per FFT bin (Fs/FFT_LEN, integer).
- EMITTED_FREQUENCY, 40000, transmit tone in Hz.
- SOUND_CMPS, 34300, speed of sound in cm/s.
- FLUSH_MAX, 4096, max cycles to wait for fft_sync before aborting.
- DEADBAND_BINS, 1, |bin offset| treated as zero velocity (optional feature only).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- start_in  in  1  pulse: arm a new measurement
- echo_detected  in  1  receiver sample valid
- receiver_data  in  16  signed receiver sample
- fft_ce  out  1  FFT clock enable
- fft_sample  out  32  {real, imag=0} FFT input
- fft_result  in  32  {real[31:16], imag[15:0]} signed FFT output
- fft_sync  in  1  FFT first-bin marker
- div_valid_out  out  1  divider start pulse
- div_dividend  out  32  |numerator|
- div_divisor  out  32  EMITTED_FREQUENCY
- div_valid_in  in  1  divider result valid
- div_quotient  in  32  divider quotient
- div_error  in  1  divider error flag
- busy_out  out  1  FSM not IDLE
- peak_bin_out  out  log2(FFT_LEN)  bin with largest magnitude
- velocity_out  out  16  signed velocity, cm/s, saturated
- velocity_valid  out  1  one-cycle result pulse
- error_out  out  1  one-cycle abort pulse (timeout or div_error)

Behaviour:
- Reset (async): state IDLE. All outputs 0, counters 0, max magnitude 0.
- IDLE: fft_ce=0. start_in -> FILL, sample counter cleared.
- FILL:
  - Each echo_detected cycle drives fft_ce=1 and fft_sample={receiver_data,16'h0}, and increments the counter.
  - Non-echo cycles hold fft_ce=0.
  - After FFT_LEN accepted samples -> FLUSH.
- FLUSH:
  - fft_ce=1 every cycle with fft_sample=0; echo_detected is ignored.
  - fft_sync with fft_ce=1 -> SCAN; bin 0 is scanned in that same cycle.
  - If the cycle counter reaches FLUSH_MAX: pulse error_out -> IDLE.
- SCAN:
  - fft_ce=1 with zero samples. Bin index increments per enabled cycle.
  - mag = re*re + im*im, signed 16x16, 32-bit unsigned sum, registered one stage.
  - Only bins 1..FFT_LEN/2-1 are candidates; DC and the upper half are ignored.
  - Strict greater-than compare, so the lowest index wins ties.
  - After bin FFT_LEN-1 -> CALC.
- CALC (1 cycle):
  - df = peak_bin*BIN_HZ - EMITTED_FREQUENCY, signed 32.
  - num = df*SOUND_CMPS, signed 48, clipped to 31 bits of magnitude.
  - Sign is latched; div_dividend = |num|.
  - div_valid_out pulses 1 cycle -> DIVIDE.
- DIVIDE:
  - Waits for div_valid_in.
  - div_error=1: pulse error_out -> IDLE.
  - Otherwise the sign is re-applied, saturated to [-32768, 32767], and registered to velocity_out with a 1-cycle velocity_valid pulse -> IDLE.
- peak_bin_out and velocity_out hold their values until the next successful result.
- start_in outside IDLE is ignored. start_in and echo_detected in the same IDLE cycle: that sample is not captured.
- Reset mid-frame aborts immediately with no error pulse. The FFT pipeline is not flushed by this block; the next frame realigns on fft_sync.
- busy_out = (state != IDLE).
- Latency: FFT_LEN echoes + FFT pipeline delay + FFT_LEN + 1 + divider latency + 1 cycles.

Optional Feature:
- Macro DOPPLER_DEADBAND_EN.
- Defined: when |peak_bin - round(EMITTED_FREQUENCY/BIN_HZ)| <= DEADBAND_BINS, CALC skips the divider and velocity_out=0 is pulsed valid the next cycle.
- Undefined: every frame goes through the divider; DEADBAND_BINS is unused.

Decomposition:
- Package sonic_pkg: state enum (IDLE, FILL, FLUSH, SCAN, CALC, DIVIDE), SAT16 limits, and the FFT word pack/unpack field constants.
- One sub-module: peak_bin_tracker, covering the magnitude pipeline plus running max/argmax with clear and enable.

Test Plan:
- Zero-input frame, forced fft_sync, all bins zero -> peak_bin 0, df = -40000, velocity_out = -32768 (saturated), velocity_valid pulse.
- Model FFT returns the peak at bin 410 (40180 Hz) -> dividend 180*34300 = 6174000, quotient 154 -> velocity_out = +154.
- No fft_sync within FLUSH_MAX -> error_out pulse at cycle FLUSH_MAX, busy_out drops, velocity_out unchanged.
- Equal magnitudes at bins 200 and 300 -> peak_bin_out = 200; bins 0 and 600 large -> ignored.
- rst_in asserted mid-SCAN, then start_in -> IDLE with outputs 0, and the second frame completes correctly.
- With DOPPLER_DEADBAND_EN, peak at bin 409 -> velocity_out = 0, div_valid_out never asserted.

Source files
------------

// File: rtl/sonic_pkg.sv
// sonic_pkg: frame FSM states, 16-bit saturation limits and FFT word {re[31:16], im[15:0]} field helpers
package sonic_pkg;
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, SCAN, CALC, DIVIDE} seq_state_t;
  localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT16_MIN = 16'sh8000;
  localparam int FFT_RE_LSB = 16;
  localparam int FFT_IM_LSB = 0;
  localparam int FFT_FIELD_W = 16;
  function automatic logic [31:0] fft_pack(input logic signed [15:0] re);
    return {re, 16'h0000};
  endfunction
  function automatic logic signed [15:0] fft_re(input logic [31:0] w);
    return w[FFT_RE_LSB +: FFT_FIELD_W];
  endfunction
  function automatic logic signed [15:0] fft_im(input logic [31:0] w);
    return w[FFT_IM_LSB +: FFT_FIELD_W];
  endfunction
endpackage

// File: rtl/peak_bin_tracker.sv
// peak_bin_tracker: registered re^2+im^2 per FFT bin, running max/argmax over bins 1..FFT_LEN/2-1 (lowest bin wins ties); ports clk_in, rst_in, clr, en, bin, fft_result -> peak_bin
module peak_bin_tracker
  import sonic_pkg::*;
#(
  parameter int FFT_LEN = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clr,
  input  logic                       en,
  input  logic [$clog2(FFT_LEN)-1:0] bin,
  input  logic [31:0]                fft_result,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin
);
  localparam int BW = $clog2(FFT_LEN);
  logic signed [15:0] re, im;
  logic signed [31:0] pr, pi;
  logic [31:0] mag, mag_r, max_mag;
  logic [BW-1:0] bin_r;
  logic cand, cand_r;
  assign re = fft_re(fft_result);
  assign im = fft_im(fft_result);
  assign pr = re * re;
  assign pi = im * im;
  assign mag = $unsigned(pr) + $unsigned(pi);
  assign cand = en && bin != '0 && !bin[BW-1];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      cand_r <= 1'b0;
      mag_r <= '0;
      bin_r <= '0;
      max_mag <= '0;
      peak_bin <= '0;
    end else if (clr) begin
      cand_r <= 1'b0;
      max_mag <= '0;
      peak_bin <= '0;
    end else begin
      cand_r <= cand;
      mag_r <= mag;
      bin_r <= bin;
      if (cand_r && mag_r > max_mag) begin
        max_mag <= mag_r;
        peak_bin <= bin_r;
      end
    end
endmodule

// File: rtl/doppler_frame_sequencer.sv
// doppler_frame_sequencer: frame FSM (fill echoes -> flush FFT to fft_sync -> scan bins for peak -> divide) producing saturated signed velocity; ports: clk_in/rst_in, start_in, echo_detected/receiver_data in, fft_ce/fft_sample out, fft_result/fft_sync in, div_* handshake, busy_out/peak_bin_out/velocity_out/velocity_valid/error_out; DOPPLER_DEADBAND_EN zeroes velocity near the carrier bin without using the divider
module doppler_frame_sequencer
  import sonic_pkg::*;
#(
  parameter int FFT_LEN = 1024,
  parameter int BIN_HZ = 98,
  parameter int EMITTED_FREQUENCY = 40000,
  parameter int SOUND_CMPS = 34300,
  parameter int FLUSH_MAX = 4096
`ifdef DOPPLER_DEADBAND_EN
  , parameter int DEADBAND_BINS = 1
`endif
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic                       echo_detected,
  input  logic [15:0]                receiver_data,
  output logic                       fft_ce,
  output logic [31:0]                fft_sample,
  input  logic [31:0]                fft_result,
  input  logic                       fft_sync,
  output logic                       div_valid_out,
  output logic [31:0]                div_dividend,
  output logic [31:0]                div_divisor,
  input  logic                       div_valid_in,
  input  logic [31:0]                div_quotient,
  input  logic                       div_error,
  output logic                       busy_out,
  output logic [$clog2(FFT_LEN)-1:0] peak_bin_out,
  output logic [15:0]                velocity_out,
  output logic                       velocity_valid,
  output logic                       error_out
);
  localparam int BW = $clog2(FFT_LEN);
  localparam int CW = $clog2(FLUSH_MAX > FFT_LEN ? FLUSH_MAX : FFT_LEN) + 1;
  seq_state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bin, peak_bin;
  logic neg, trk_en, in_db;
  logic signed [31:0] pb, df;
  logic signed [47:0] num;
  logic [47:0] num_abs;
  logic [31:0] dividend;
  logic [15:0] vel_sat;
  assign fft_ce = state == FILL ? echo_detected : (state == FLUSH || state == SCAN);
  assign fft_sample = (state == FILL && echo_detected) ? fft_pack(receiver_data) : '0;
  assign busy_out = state != IDLE;
  assign trk_en = state == SCAN || (state == FLUSH && fft_sync);
  assign pb = {{(32 - BW){1'b0}}, peak_bin};
  assign df = pb * BIN_HZ - EMITTED_FREQUENCY;
  assign num = 48'(df) * 48'(SOUND_CMPS);
  assign num_abs = num[47] ? -num : num;
  assign dividend = |num_abs[47:31] ? 32'h7FFF_FFFF : num_abs[31:0];
  assign vel_sat = neg ? (div_quotient > 32'd32768 ? SAT16_MIN : 16'(32'd0 - div_quotient))
                       : (div_quotient > 32'd32767 ? SAT16_MAX : div_quotient[15:0]);
`ifdef DOPPLER_DEADBAND_EN
  localparam int CENTER = (EMITTED_FREQUENCY + BIN_HZ / 2) / BIN_HZ;
  assign in_db = pb >= CENTER - DEADBAND_BINS && pb <= CENTER + DEADBAND_BINS;
`else
  assign in_db = 1'b0;
`endif
  peak_bin_tracker #(.FFT_LEN(FFT_LEN)) u_tracker (
    .clk_in,
    .rst_in,
    .clr(state == IDLE && start_in),
    .en(trk_en),
    .bin(state == SCAN ? bin : '0),
    .fft_result,
    .peak_bin
  );
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      neg <= 1'b0;
      div_valid_out <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      peak_bin_out <= '0;
      velocity_out <= '0;
      velocity_valid <= 1'b0;
      error_out <= 1'b0;
    end else begin
      div_valid_out <= 1'b0;
      velocity_valid <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          state <= FILL;
          cnt <= '0;
        end
        FILL: if (echo_detected) begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(FFT_LEN - 1)) begin
            state <= FLUSH;
            cnt <= '0;
          end
        end
        FLUSH: begin
          cnt <= cnt + CW'(1);
          if (fft_sync) begin
            state <= SCAN;
            bin <= BW'(1);
          end else if (cnt == CW'(FLUSH_MAX - 1)) begin
            state <= IDLE;
            error_out <= 1'b1;
          end
        end
        SCAN: begin
          bin <= bin + BW'(1);
          if (bin == BW'(FFT_LEN - 1)) state <= CALC;
        end
        CALC: begin
          neg <= num[47];
          div_dividend <= dividend;
          div_divisor <= 32'(EMITTED_FREQUENCY);
          if (in_db) begin
            velocity_out <= '0;
            velocity_valid <= 1'b1;
            peak_bin_out <= peak_bin;
            state <= IDLE;
          end else begin
            div_valid_out <= 1'b1;
            state <= DIVIDE;
          end
        end
        DIVIDE: if (div_valid_in) begin
          state <= IDLE;
          if (div_error) error_out <= 1'b1;
          else begin
            velocity_out <= vel_sat;
            velocity_valid <= 1'b1;
            peak_bin_out <= peak_bin;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_doppler_frame_sequencer.sv
// tb_doppler_frame_sequencer: directed frames against a model FFT output stream and a model divider
module tb_doppler_frame_sequencer;
  localparam int FFT_LEN = 1024;
  localparam int FLUSH_MAX = 4096;
  logic clk_in = 0, rst_in = 1, start_in = 0, echo_detected = 0, fft_sync = 0;
  logic div_valid_in = 0, div_error = 0;
  logic [15:0] receiver_data = 0;
  logic [31:0] fft_result = 0, div_quotient = 0;
  logic fft_ce, div_valid_out, busy_out, velocity_valid, error_out;
  logic [31:0] fft_sample, div_dividend, div_divisor;
  logic [9:0] peak_bin_out;
  logic [15:0] velocity_out;
  int n_tests = 0, n_fail = 0;
  always #5 clk_in = ~clk_in;
  doppler_frame_sequencer dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .echo_detected(echo_detected),
    .receiver_data(receiver_data),
    .fft_ce(fft_ce),
    .fft_sample(fft_sample),
    .fft_result(fft_result),
    .fft_sync(fft_sync),
    .div_valid_out(div_valid_out),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_valid_in(div_valid_in),
    .div_quotient(div_quotient),
    .div_error(div_error),
    .busy_out(busy_out),
    .peak_bin_out(peak_bin_out),
    .velocity_out(velocity_out),
    .velocity_valid(velocity_valid),
    .error_out(error_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] bin_val(input int pat, input int b);
    case (pat)
      1: return b == 410 ? {16'd1000, 16'd0} : b == 100 ? {16'd500, 16'd500} : 32'h0;
      2: return b == 200 ? {16'd500, 16'd0} : b == 300 ? {16'hFED4, 16'hFE70} :
                (b == 0 || b == 600) ? {16'd20000, 16'd20000} : 32'h0;
      3: return b == 409 ? {16'd1000, 16'd0} : 32'h0;
      4: return b == 511 ? {16'd2000, 16'd0} : b == 512 ? {16'd30000, 16'd0} :
                b == 1 ? {16'd10, 16'd0} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction
  task automatic fill_frame();
    @(negedge clk_in);
    start_in = 1;
    echo_detected = 1;
    receiver_data = 16'h1234;
    @(negedge clk_in);
    start_in = 0;
    for (int i = 0; i < FFT_LEN; i++) begin
      if (i == FFT_LEN - 1) begin
        echo_detected = 0;
        #1 check("fill_gap", fft_ce, 1'b0);
        @(negedge clk_in);
      end
      echo_detected = 1;
      receiver_data = 16'(i * 3 - 7);
      if (i == 5) #1 check("fill_ce", {fft_ce, fft_sample}, {1'b1, 16'd8, 16'h0});
      @(negedge clk_in);
    end
    echo_detected = 1;
    receiver_data = 16'h7777;
    #1 check("flush_ce", {busy_out, fft_ce, fft_sample}, {2'b11, 32'h0});
    echo_detected = 0;
  endtask
  task automatic feed_bins(input int pat, input int n);
    repeat (10) @(negedge clk_in);
    for (int b = 0; b < n; b++) begin
      fft_sync = b == 0;
      fft_result = bin_val(pat, b);
      @(negedge clk_in);
    end
    fft_sync = 0;
    fft_result = 0;
  endtask
  task automatic run_divide(input bit derr, input logic [31:0] exp_dvd, output bit got_div);
    got_div = 0;
    for (int i = 0; i < 10 && !got_div && !velocity_valid && !error_out; i++) begin
      @(negedge clk_in);
      got_div = div_valid_out;
    end
    if (got_div) begin
      check("dividend", {div_divisor, div_dividend}, {32'd40000, exp_dvd});
      @(negedge clk_in);
      check("div_pulse", {div_valid_out, busy_out}, 2'b01);
      @(negedge clk_in);
      div_valid_in = 1;
      div_error = derr;
      div_quotient = derr ? 32'hDEAD : exp_dvd / 32'd40000;
      @(negedge clk_in);
      div_valid_in = 0;
      div_error = 0;
    end
  endtask
  task automatic frame(input int pat, input bit derr, input logic [31:0] exp_dvd,
                       input logic [15:0] exp_vel, input logic [9:0] exp_pk, input string tag);
    bit got;
    fill_frame();
    feed_bins(pat, FFT_LEN);
    run_divide(derr, exp_dvd, got);
    check({tag, "_div"}, got, 1'b1);
    check({tag, "_res"}, {velocity_valid, error_out, busy_out, velocity_out, peak_bin_out},
          {~derr, derr, 1'b0, exp_vel, exp_pk});
    @(negedge clk_in);
    check({tag, "_pulse"}, {velocity_valid, error_out}, 2'b00);
  endtask
  initial begin
    int n;
    bit got;
    repeat (2) @(negedge clk_in);
    check("rst_a", {fft_ce, fft_sample, div_valid_out, div_dividend}, '0);
    check("rst_b", {div_divisor, busy_out, peak_bin_out, velocity_out, velocity_valid, error_out}, '0);
    rst_in = 0;
    echo_detected = 1;
    receiver_data = 16'h5555;
    #1 check("idle_ce", {fft_ce, fft_sample, busy_out}, '0);
    echo_detected = 0;
    frame(0, 0, 32'd1372000000, 16'h8000, 10'd0, "zero");
    frame(1, 0, 32'd6174000, 16'd154, 10'd410, "b410");
    fill_frame();
    n = 0;
    while (!error_out && n < 2 * FLUSH_MAX) begin
      @(negedge clk_in);
      n++;
    end
    check("to_cycles", n, FLUSH_MAX);
    check("to_state", {error_out, busy_out, velocity_out, peak_bin_out}, {2'b10, 16'd154, 10'd410});
    @(negedge clk_in);
    check("to_pulse", error_out, 1'b0);
    frame(2, 0, 32'd699720000, 16'hBBAB, 10'd200, "ties");
    frame(4, 1, 32'd345675400, 16'hBBAB, 10'd200, "derr");
    frame(4, 0, 32'd345675400, 16'd8641, 10'd511, "b511");
    fill_frame();
    feed_bins(1, 300);
    rst_in = 1;
    #1 check("rst_mid", {busy_out, fft_ce, velocity_out, peak_bin_out, velocity_valid, error_out, div_valid_out}, '0);
    @(negedge clk_in);
    rst_in = 0;
    frame(1, 0, 32'd6174000, 16'd154, 10'd410, "rerun");
    fill_frame();
    feed_bins(3, FFT_LEN);
    run_divide(0, 32'd2812600, got);
`ifdef DOPPLER_DEADBAND_EN
    check("db_nodiv", got, 1'b0);
    check("db_res", {velocity_valid, busy_out, velocity_out, peak_bin_out}, {2'b10, 16'd0, 10'd409});
`else
    check("b409_div", got, 1'b1);
    check("b409_res", {velocity_valid, busy_out, velocity_out, peak_bin_out}, {2'b10, 16'd70, 10'd409});
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
